// File: rtl/seq_compare.sv
// seq_compare: serial magnitude comparator. Two WIDTH-bit operands are
// captured on an accepted start and compared one 2-bit pair per cycle, LSB
// pair first. A later, more significant pair that differs overrides the
// verdict of the lower pairs, so the result after the MSB pair is the full
// comparison.
//
// Configuration macro: SEQ_COMPARE_SIGNED_EN
//   defined   - operands are two's complement. The sign bits are inverted in
//               the final (MSB) pair before that pair is compared.
//   undefined - unsigned compare. No sign handling logic is built.
// Latency and handshake are the same in both builds.
//
// Ports:
//   clk     in   clock, all state changes on the rising edge
//   rst     in   synchronous active-high reset, has priority over start
//   start   in   begin a comparison; sampled only in IDLE
//   a, b    in   operands [WIDTH-1:0]; sampled only on the accepted start cycle
//   busy    out  high while in RUN
//   done    out  one-cycle pulse in DONE; greater/less are valid from here on
//   greater out  a > b
//   less    out  a < b (greater = less = 0 after done means a == b)
//
// Handshake: start is a request with no acknowledge. It is taken on any
// rising edge where the FSM is in IDLE and rst is low, and ignored otherwise.
// done marks the result. The result then holds until the next accepted start
// or reset.
module seq_compare #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             greater,
  output logic             less
);

  localparam int PAIRS = WIDTH / 2;
  localparam int CW    = (PAIRS > 1) ? $clog2(PAIRS) : 1;
  localparam logic [CW-1:0] LAST = CW'(PAIRS - 1);

  generate
    if ((WIDTH < 2) || ((WIDTH % 2) != 0)) begin : g_bad_width
      $error("seq_compare: WIDTH must be even and >= 2");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state, state_next;
  logic [WIDTH-1:0] sa, sa_next;
  logic [WIDTH-1:0] sb, sb_next;
  logic [CW-1:0]   cnt, cnt_next;
  logic            greater_next, less_next;
  logic [1:0]      pa, pb;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      sa      <= '0;
      sb      <= '0;
      cnt     <= '0;
      greater <= 1'b0;
      less    <= 1'b0;
    end else begin
      state   <= state_next;
      sa      <= sa_next;
      sb      <= sb_next;
      cnt     <= cnt_next;
      greater <= greater_next;
      less    <= less_next;
    end
  end

  always_comb begin
    state_next   = state;
    sa_next      = sa;
    sb_next      = sb;
    cnt_next     = cnt;
    greater_next = greater;
    less_next    = less;
    pa           = sa[1:0];
    pb           = sb[1:0];
`ifdef SEQ_COMPARE_SIGNED_EN
    // Inverting the sign bits maps two's complement order onto unsigned
    // order. Only the MSB pair carries the sign.
    if (cnt == LAST) begin
      pa[1] = ~sa[1];
      pb[1] = ~sb[1];
    end
`endif
    case (state)
      IDLE: begin
        if (start) begin
          state_next   = RUN;
          sa_next      = a;
          sb_next      = b;
          cnt_next     = '0;
          greater_next = 1'b0;
          less_next    = 1'b0;
        end
      end
      RUN: begin
        // An equal pair keeps the verdict of the lower pairs.
        if (pa > pb) begin
          greater_next = 1'b1;
          less_next    = 1'b0;
        end else if (pa < pb) begin
          greater_next = 1'b0;
          less_next    = 1'b1;
        end
        sa_next  = sa >> 2;
        sb_next  = sb >> 2;
        cnt_next = cnt + CW'(1);
        if (cnt == LAST) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: doc/seq_compare.md
SEQ_COMPARE -- requirements
Module: seq_compare

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits; it must be even and at least 2, and is checked at elaboration.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin a comparison, sampled only in IDLE.
REQ-005 The block SHALL have port a, input, WIDTH bits: first operand, sampled on the accepted start cycle only.
REQ-006 The block SHALL have port b, input, WIDTH bits: second operand, sampled on the accepted start cycle only.
REQ-007 The block SHALL have port busy, output, 1 bit: high while in RUN.
REQ-008 The block SHALL have port done, output, 1 bit: one-cycle pulse in DONE, marking greater/less valid.
REQ-009 The block SHALL have port greater, output, 1 bit: result a > b.
REQ-010 The block SHALL have port less, output, 1 bit: result a < b.

Function
REQ-011 The block SHALL use FSM states IDLE, RUN and DONE.
REQ-012 Transitions SHALL be:
  - IDLE -> RUN when start=1;
  - RUN -> DONE after the last pair is processed;
  - DONE -> IDLE unconditionally.
REQ-013 On an accepted start, the block SHALL latch a and b into internal shift registers, clear the pair counter to 0, and clear greater and less to 0.
REQ-014 In each RUN cycle, the block SHALL process one 2-bit pair, LSB pair first (bits [1:0], then [3:2], ...), and shift both registers right by 2.
REQ-015 Per-pair update SHALL be:
  - pair_a > pair_b: greater=1, less=0;
  - pair_a < pair_b: greater=0, less=1;
  - pair_a == pair_b: greater and less are held.
  Because higher pairs are processed later, they override lower ones.
REQ-016 RUN SHALL last exactly WIDTH/2 cycles; the pair counter width SHALL be $clog2(WIDTH/2) with a minimum of 1 bit.
REQ-017 Latency: if start is sampled at edge 0, busy SHALL be high in cycles 1..WIDTH/2, done SHALL be high in cycle WIDTH/2+1 only, and the FSM SHALL be in IDLE in cycle WIDTH/2+2.
REQ-018 greater and less SHALL never be 1 simultaneously; both 0 after DONE means a == b.
REQ-019 greater and less SHALL hold their final values from DONE until the next accepted start or reset.
REQ-020 start SHALL be ignored in RUN and DONE, with no effect on operands, counter or outputs.
REQ-021 Back-to-back operation: start held high continuously SHALL be accepted at every IDLE, giving one comparison per WIDTH/2+2 cycles.
REQ-022 Changes on a and b after the accepted start cycle SHALL NOT affect the result.

Reset
REQ-023 While rst=1 at a clock edge, the block SHALL force state IDLE and clear busy, done, greater, less, the counter and the shift registers to 0.
REQ-024 rst SHALL take priority over start.
REQ-025 rst asserted mid-RUN or in DONE SHALL abort the comparison, with no done pulse.
REQ-026 The first start SHALL be accepted in the first cycle with rst=0.

Configuration
REQ-027 The behaviour SHALL be controlled by macro SEQ_COMPARE_SIGNED_EN:
  - defined: operands are two's complement; in the final (MSB) pair the sign bits are inverted in both operands before the per-pair compare;
  - undefined: unsigned compare, no sign handling logic is generated.
REQ-028 Latency and handshake SHALL be identical in both configurations.

Verification
REQ-029 A bench SHALL cover WIDTH=8, a=0x5A, b=0x5A, start one cycle -> busy high cycles 1-4, done high cycle 5, greater=0, less=0.
REQ-030 A bench SHALL cover a=0x01, b=0x00 -> greater=1, less=0; then a=0x10, b=0x0F -> greater=1, showing the higher pair overrides the lower.
REQ-031 A bench SHALL cover a=0x80, b=0x7F -> greater=1 unsigned; with SEQ_COMPARE_SIGNED_EN defined -> less=1, greater=0.
REQ-032 A bench SHALL cover start pulsed in RUN cycle 2 with different a/b -> ignored; the result reflects the original operands; exactly one done pulse.
REQ-033 A bench SHALL cover rst asserted in RUN cycle 3 -> next cycle IDLE, all outputs 0, no done pulse; a following start completes normally.
REQ-034 A bench SHALL cover start held high with a/b changing every cycle -> a done pulse every 6 cycles, each result matching the operands sampled at its own accept cycle.
